// File: rtl/bram_stream_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | bram_stream_reader: credit-limited BRAM window reader with valid/ready out.  |
// | Optional: define BRAM_RD_WRAP_EN for modulo-DEPTH wrap (else clip at end).   |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module bram_stream_reader #(
   parameter int DEPTH      = 5130,
   parameter int BITS_D     = 20,
   parameter int BITS_A     = $clog2(DEPTH),
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [BITS_A-1:0] base,
   input  logic [BITS_A:0]   len,
   output logic              busy,
   output logic              done,
   output logic [BITS_A-1:0] bram_addr,
   input  logic [BITS_D-1:0] bram_rdata,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [BITS_D-1:0] o_data,
   output logic              o_last
);
   localparam int FIFO_DEPTH = RD_LATENCY + 2;
   localparam int c_PTR_W    = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W    = $clog2(FIFO_DEPTH + 1) + 1;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_RUN   = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;

   localparam logic [BITS_A:0]    c_DEPTH_W = (BITS_A + 1)'(DEPTH);
   localparam logic [BITS_A:0]    c_ONE_W   = (BITS_A + 1)'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_TOP = c_PTR_W'(FIFO_DEPTH - 1);

   logic [1:0]          r_state, w_state_nxt;
   logic [BITS_A-1:0]   r_addr, w_addr_nxt;
   logic [BITS_A:0]     r_irem, r_orem, w_count;
   logic [RD_LATENCY:0] r_tag;
   logic [c_CNT_W-1:0]  r_fcnt, w_pipe_cnt, w_outstanding;
   logic [c_PTR_W-1:0]  r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
   logic [BITS_D-1:0]   r_mem [FIFO_DEPTH];
   logic                r_done;
   logic                w_legal, w_start_ok, w_accept, w_degen;
   logic                w_issue, w_credit, w_push, w_pop;

   assign w_legal    = (len != '0) && ({1'b0, base} < c_DEPTH_W);
   assign w_start_ok = start && w_legal;
   assign w_accept   = (r_state == c_IDLE) && w_start_ok;
   assign w_degen    = (r_state == c_IDLE) && start && !w_legal;

`ifdef BRAM_RD_WRAP_EN
   localparam logic [BITS_A-1:0] c_LAST_ADDR = BITS_A'(DEPTH - 1);
   assign w_count    = len;
   assign w_addr_nxt = (r_addr == c_LAST_ADDR) ? '0 : r_addr + BITS_A'(1);
`else
   logic [BITS_A:0] w_room;
   assign w_room     = c_DEPTH_W - {1'b0, base};
   assign w_count    = (len < w_room) ? len : w_room;
   assign w_addr_nxt = r_addr + BITS_A'(1);
`endif

   // Credit covers the address register stage, the latency pipe and the FIFO;
   // a pop in this cycle frees a slot for an issue in the same cycle.
   always_comb begin
      w_pipe_cnt = '0;
      for (int k = 0; k <= RD_LATENCY; k++)
         w_pipe_cnt = w_pipe_cnt + c_CNT_W'(r_tag[k]);
   end

   assign w_outstanding = w_pipe_cnt + r_fcnt;
   assign w_pop         = o_valid && o_ready;
   assign w_credit      = (w_outstanding - c_CNT_W'(w_pop)) < c_CNT_W'(FIFO_DEPTH);
   assign w_push        = r_tag[RD_LATENCY];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= c_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_accept) w_state_nxt = (w_count == c_ONE_W) ? c_DRAIN : c_RUN;
         c_RUN:   if (w_issue && r_irem == c_ONE_W) w_state_nxt = c_DRAIN;
         c_DRAIN: if (w_pop && o_last) w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      w_issue = 1'b0;
      case (r_state)
         c_IDLE:  w_issue = w_start_ok;
         c_RUN:   begin busy = 1'b1; w_issue = w_credit; end
         c_DRAIN: busy = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_addr <= '0;
         r_irem <= '0;
         r_orem <= '0;
         r_tag  <= '0;
         r_done <= 1'b0;
      end else begin
         r_tag  <= {r_tag[RD_LATENCY-1:0], w_issue};
         r_done <= w_degen || (w_pop && o_last);
         if (w_accept) begin
            r_addr <= base;
            r_irem <= w_count - c_ONE_W;
         end else if (w_issue) begin
            r_addr <= w_addr_nxt;
            r_irem <= r_irem - c_ONE_W;
         end
         if (w_accept)   r_orem <= w_count;
         else if (w_pop) r_orem <= r_orem - c_ONE_W;
      end
   end

   assign w_wptr_nxt = (r_wptr == c_PTR_TOP) ? '0 : r_wptr + c_PTR_W'(1);
   assign w_rptr_nxt = (r_rptr == c_PTR_TOP) ? '0 : r_rptr + c_PTR_W'(1);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= bram_rdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fcnt <= '0;
      end else begin
         if (w_push) r_wptr <= w_wptr_nxt;
         if (w_pop)  r_rptr <= w_rptr_nxt;
         r_fcnt <= r_fcnt + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
   end

   assign o_valid   = (r_fcnt != '0);
   assign o_data    = o_valid ? r_mem[r_rptr] : '0;
   assign o_last    = o_valid && (r_orem == c_ONE_W);
   assign done      = r_done;
   assign bram_addr = r_addr;

endmodule
`default_nettype wire
